// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one synchronous word memory between fetch (IF) and load/store (LS); define ARB_PERF_CNT_EN for stall counters
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]       if_stall_cnt,
  output logic [15:0]       ls_stall_cnt,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     state;
  logic       last_srv;
  logic [1:0] cnt;
  logic       win_ls;
  // LS wins when it is alone or when IF was served last; last_srv doubles as the current owner
  assign win_ls = ls_req && (!if_req || !last_srv);
  // transaction FSM; mem_addr/mem_wdata act as the latched command and hold between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_srv  <= 1'b1;
      cnt       <= '0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE: if (if_req || ls_req) begin
          state    <= ISSUE;
          last_srv <= win_ls;
          if_gnt   <= !win_ls;
          ls_gnt   <= win_ls;
          mem_en   <= 1'b1;
          mem_we   <= win_ls && ls_we;
          mem_addr <= win_ls ? ls_addr : if_addr;
          if (win_ls) mem_wdata <= ls_wdata;
        end
        ISSUE: begin
          state <= mem_we ? IDLE : WAIT;
          cnt   <= 2'(MEM_LAT - 1);
        end
        WAIT: if (cnt == '0) begin
          state <= RESP;
          if (last_srv) begin
            ls_rdata  <= mem_rdata;
            ls_rvalid <= 1'b1;
          end else begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end
        end else cnt <= cnt - 2'd1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ARB_PERF_CNT_EN
  // saturating count of cycles a requester is waiting without being granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_cnt <= '0;
      ls_stall_cnt <= '0;
    end else begin
      if (if_req && !if_gnt && if_stall_cnt != 16'hFFFF) if_stall_cnt <= if_stall_cnt + 16'd1;
      if (ls_req && !ls_gnt && ls_stall_cnt != 16'hFFFF) ls_stall_cnt <= ls_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven bench for mem_port_arbiter over MEM_LAT 1..4
module tb_mem_port_arbiter;
  logic        clk;
  logic        rst_n;
  logic        if_req    [4];
  logic [7:0]  if_addr   [4];
  logic        if_gnt    [4];
  logic        if_rvalid [4];
  logic [15:0] if_rdata  [4];
  logic        ls_req    [4];
  logic        ls_we     [4];
  logic [7:0]  ls_addr   [4];
  logic [15:0] ls_wdata  [4];
  logic        ls_gnt    [4];
  logic        ls_rvalid [4];
  logic [15:0] ls_rdata  [4];
  logic        mem_en    [4];
  logic        mem_we    [4];
  logic [7:0]  mem_addr  [4];
  logic [15:0] mem_wdata [4];
  logic [15:0] mem_rdata [4];
`ifdef ARB_PERF_CNT_EN
  logic [15:0] if_stall_cnt [4];
  logic [15:0] ls_stall_cnt [4];
`endif
  int n_chk = 0;
  int n_fail = 0;

  // unwritten memory words read as this pattern (0x10 -> 0x004C)
  function automatic logic [15:0] f(input logic [7:0] a);
    return {8'h00, a} ^ 16'h005C;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [15:0] mem  [256];
    bit          wr   [256];
    logic [15:0] pipe [4];
    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(g + 1)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]), .ls_wdata(ls_wdata[g]),
      .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
`ifdef ARB_PERF_CNT_EN
      .if_stall_cnt(if_stall_cnt[g]), .ls_stall_cnt(ls_stall_cnt[g]),
`endif
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g]] <= mem_wdata[g];
        wr[mem_addr[g]]  <= 1'b1;
      end
      if (mem_en[g] && !mem_we[g]) pipe[0] <= wr[mem_addr[g]] ? mem[mem_addr[g]] : f(mem_addr[g]);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[g];
  end

  typedef struct {
    logic        ir;
    logic [7:0]  ia;
    logic        lr;
    logic        lw;
    logic [7:0]  la;
    logic [15:0] ld;
    logic        eig;
    logic        elg;
    logic        een;
    logic        ewe;
    logic [7:0]  ea;
    logic        eiv;
    logic        elv;
    logic [15:0] erd;
    logic [15:0] ewd;
  } vec_t;
  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int d;
    int nv;
    for (int g = 0; g < 4; g++) begin
      if_req[g] = 1'b0; if_addr[g] = '0;
      ls_req[g] = 1'b0; ls_we[g] = 1'b0; ls_addr[g] = '0; ls_wdata[g] = '0;
    end
    // inputs applied during a cycle, outputs expected in the following cycle
    //             ir    ia     lr    lw    la     ld        eig   elg   een   ewe   ea     eiv   elv   erd        ewd
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 16'h004C, 16'h0000});
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1, 16'h006C, 16'h0000});
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 16'h004C, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 16'h0000, 16'hBEEF});
    tbl.push_back('{1'b0, 8'h10, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1, 16'hBEEF, 16'h0000});
    tbl.push_back('{1'b0, 8'h10, 1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 16'h0000, 16'h0000});

    // reset held with both requests pending
    rst_n = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 8'h10;
    ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 8'h30;
    repeat (3) tick();
    chk("rst gnt", {if_gnt[0], ls_gnt[0]}, 0);
    chk("rst mem", {mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]}, 0);
    chk("rst rvalid", {if_rvalid[0], ls_rvalid[0]}, 0);
    chk("rst rdata", {if_rdata[0], ls_rdata[0]}, 0);
    rst_n = 1'b1;
    tick();
    chk("first if_gnt", if_gnt[0], 1);
    chk("first ls_gnt", ls_gnt[0], 0);
    chk("first mem_en", mem_en[0], 1);
    chk("first mem_addr", mem_addr[0], 8'h10);

    // contention, store, then load of the stored word on MEM_LAT=1
    for (int i = 0; i < tbl.size(); i++) begin
      if_req[0] = tbl[i].ir; if_addr[0] = tbl[i].ia;
      ls_req[0] = tbl[i].lr; ls_we[0] = tbl[i].lw; ls_addr[0] = tbl[i].la; ls_wdata[0] = tbl[i].ld;
      tick();
      chk($sformatf("row%0d gnt", i), {if_gnt[0], ls_gnt[0]}, {tbl[i].eig, tbl[i].elg});
      chk($sformatf("row%0d mem_en/we", i), {mem_en[0], mem_we[0]}, {tbl[i].een, tbl[i].ewe});
      chk($sformatf("row%0d mem_addr", i), mem_addr[0], tbl[i].ea);
      chk($sformatf("row%0d rvalid", i), {if_rvalid[0], ls_rvalid[0]}, {tbl[i].eiv, tbl[i].elv});
      if (tbl[i].eiv) chk($sformatf("row%0d if_rdata", i), if_rdata[0], tbl[i].erd);
      if (tbl[i].elv) chk($sformatf("row%0d ls_rdata", i), ls_rdata[0], tbl[i].erd);
      if (tbl[i].ewe) chk($sformatf("row%0d mem_wdata", i), mem_wdata[0], tbl[i].ewd);
    end
    chk("if_rdata held", if_rdata[0], 16'h004C);
    chk("ls_rdata held", ls_rdata[0], 16'hBEEF);
`ifdef ARB_PERF_CNT_EN
    chk("if_stall_cnt", if_stall_cnt[0], 8);
    chk("ls_stall_cnt", ls_stall_cnt[0], 13);
`endif

    // latency sweep: gnt to rvalid is MEM_LAT+1 cycles
    for (int g = 0; g < 4; g++) begin
      if_req[g] = 1'b1; if_addr[g] = 8'h40 + 8'(g);
      tick();
      chk($sformatf("lat%0d gnt", g + 1), if_gnt[g], 1);
      if_req[g] = 1'b0;
      d = 0;
      do begin
        tick();
        d++;
      end while (!if_rvalid[g] && d < 12);
      chk($sformatf("lat%0d delay", g + 1), d, g + 2);
      chk($sformatf("lat%0d rdata", g + 1), if_rdata[g], f(8'h40 + 8'(g)));
      tick();
      chk($sformatf("lat%0d rvalid pulse", g + 1), if_rvalid[g], 0);
    end

    // reset during WAIT on MEM_LAT=3 drops the read
    if_req[2] = 1'b1; if_addr[2] = 8'h55;
    tick();
    chk("midrst gnt", if_gnt[2], 1);
    if_req[2] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst outputs", {if_gnt[2], if_rvalid[2], mem_en[2], mem_addr[2]}, 0);
`ifdef ARB_PERF_CNT_EN
    chk("midrst stall cnt", {if_stall_cnt[0], ls_stall_cnt[0]}, 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_rvalid[2]) nv++;
    end
    chk("midrst no rvalid", nv, 0);
    if_req[2] = 1'b1; if_addr[2] = 8'h55;
    tick();
    chk("rereq gnt", if_gnt[2], 1);
    if_req[2] = 1'b0;
    d = 0;
    do begin
      tick();
      d++;
    end while (!if_rvalid[2] && d < 12);
    chk("rereq delay", d, 4);
    chk("rereq rdata", if_rdata[2], 16'h0009);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-ported synchronous word memory between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the core's fetch/execute logic and the memory instance.
- Round-robin arbitration, one outstanding memory transaction at a time, fixed memory read latency.

Parameters:
ADDR_W, 8, word-address width.
DATA_W, 16, data word width.
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..4.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request; level signal, held until if_gnt.
if_addr  in  ADDR_W  fetch address; stable while if_req=1.
if_gnt  out  1  one-cycle pulse when the fetch command is issued to memory.
if_rvalid  out  1  one-cycle pulse when if_rdata is valid.
if_rdata  out  DATA_W  fetched word; holds its value between pulses.
ls_req  in  1  load/store request; level signal, held until ls_gnt.
ls_we  in  1  1 = store, 0 = load.
ls_addr  in  ADDR_W  load/store address.
ls_wdata  in  DATA_W  store data.
ls_gnt  out  1  one-cycle pulse when the LS command is issued; for a store this is also completion.
ls_rvalid  out  1  one-cycle pulse when ls_rdata is valid (loads only).
ls_rdata  out  DATA_W  loaded word; holds its value between pulses.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - In reset, every output is 0, the FSM is IDLE, the wait counter is 0 and last_srv=LS (so IF wins the first tie).
- All outputs are registered. There are no combinational paths from input to output.
- FSM states:
  - IDLE: if any request is pending, select a winner, latch its address, we and wdata, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (one cycle): drive mem_en=1, mem_we, mem_addr and mem_wdata from the latched values, and pulse the winner's gnt.
    - Store: go to IDLE.
    - Read (fetch or load): go to WAIT with the counter loaded to MEM_LAT-1.
  - WAIT: decrement the counter each cycle.
    - When the counter reaches 0, capture mem_rdata into the winner's rdata register and go to RESP.
    - Capture point: the issue cycle is E; mem_rdata is sampled at the end of cycle E+MEM_LAT.
  - RESP (one cycle): pulse the winner's rvalid with rdata valid, then go to IDLE.
- Latency (req first seen high in IDLE during cycle N):
  - gnt and mem_en high in cycle N+1.
  - rvalid high in cycle N+MEM_LAT+2.
  - Store completes with gnt in cycle N+1.
- Throughput: one read per MEM_LAT+3 cycles; one store per 2 cycles.
- Arbitration: evaluated only in IDLE.
  - Only one request pending: that requester wins.
  - Both pending: the requester other than last_srv wins.
  - last_srv updates to the winner on entry to ISSUE.
- Outside ISSUE, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- Requests that change or drop before gnt are a protocol violation. The arbiter uses only the values latched in IDLE.
- A requester may raise a new req in the cycle after its rvalid, or after gnt for a store.
- The non-winning requester waits with no timeout. Round-robin bounds its wait to one transaction.
- rdata registers are updated only at capture and are otherwise stable. rvalid never asserts for stores.
- Reset mid-transaction: all state and outputs clear immediately. An in-flight read is dropped with no rvalid, and requesters must re-request.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds output ports if_stall_cnt and ls_stall_cnt, each 16 bits.
  - A counter increments in every cycle where its req=1 and the arbiter is not issuing that requester's command (gnt=0).
  - Counters saturate at 16'hFFFF and are cleared by rst_n.
- Undefined: no counters or ports exist. Core behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with both reqs high -> all outputs 0. Release -> IF granted first, with if_gnt exactly 1 cycle after release-edge sampling.
- Single fetch, MEM_LAT=1: mem[8'h10]=16'h004C, if_req with if_addr=8'h10 in cycle N -> if_gnt and mem_en in N+1, if_rvalid with if_rdata=16'h004C in N+3.
- Store then load: ls_we=1, addr 8'h20, wdata 16'hBEEF -> mem_we=1 for one cycle with ls_gnt. Then a load from 8'h20 -> ls_rvalid with ls_rdata=16'hBEEF.
- Contention: if_req and ls_req held continuously -> grants alternate IF, LS, IF, LS. No requester is granted twice in a row.
- Latency sweep MEM_LAT=1..4: read delay from gnt to rvalid = MEM_LAT+1 cycles. Captured data matches memory model.
- Reset mid-WAIT (MEM_LAT=3): assert rst_n=0 during WAIT -> no rvalid ever appears for that read. After release, re-request completes normally. With ARB_PERF_CNT_EN defined, stall counters read 0 after reset.
